// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter: FSM states,
// width functions and the rotate-and-find-first search used by rr_pick.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // First set bit of req at or above ptr, wrapping modulo n; ptr must be < n.
  function automatic pick_t rr_find_first(input logic [MAX_REQ-1:0] req,
                                          input int n, input int ptr);
    pick_t r;
    int    j;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      j = ptr + i;
      if (j >= n) j = j - n;
      if (i < n && !r.found && req[j]) begin
        r.found = 1'b1;
        r.idx   = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after
// rr_ptr, wrapping around NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]           req,
  input  logic [id_width(NUM_REQ)-1:0] rr_ptr,
  output logic                         valid,
  output logic [id_width(NUM_REQ)-1:0] idx
);

  localparam int ID_W = id_width(NUM_REQ);

  pick_t              pick;
  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick                   = rr_find_first(req_ext, NUM_REQ, int'(rr_ptr));
    valid                  = pick.found;
    idx                    = pick.idx[ID_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-granular round-robin arbiter sharing one async FIFO write port among
// NUM_REQ producers. Optional idle-owner release under `FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_wfull,
  output logic                         fifo_winc,
  output logic [WIDTH-1:0]             fifo_wdata,
  output logic [id_width(NUM_REQ)-1:0] grant_id,
  output logic                         busy,
`ifdef FIFO_ARB_TIMEOUT_EN
  output logic                         timeout_evt,
`endif
  output arb_state_e                   state_dbg
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state, state_d;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_d, grant_d, next_ptr;
  logic [CNT_W-1:0] beat_cnt, beat_d;
  logic             pick_valid, owner_valid, owner_last;
  logic [ID_W-1:0]  pick_idx;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);
  logic [IDLE_W-1:0] idle_cnt, idle_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign busy      = (state == XFER);
  assign state_dbg = state;
  assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
`ifdef FIFO_ARB_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      grant_id <= grant_d;
      beat_cnt <= beat_d;
`ifdef FIFO_ARB_TIMEOUT_EN
      idle_cnt <= idle_d;
`endif
    end
  end

  // Handshake: a beat of producer i transfers in a cycle where req_valid[i]
  // and req_ready[i] are both high; ready is offered only to the owner, only
  // while the FIFO is not full, and never depends on the owner's valid.
  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    grant_d     = grant_id;
    beat_d      = beat_cnt;
    req_ready   = '0;
    fifo_winc   = 1'b0;
    fifo_wdata  = '0;
    owner_valid = req_valid[grant_id];
    owner_last  = req_last[grant_id];
`ifdef FIFO_ARB_TIMEOUT_EN
    idle_d      = idle_cnt;
    timeout_evt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d = XFER;
          grant_d = pick_idx;
          beat_d  = '0;
`ifdef FIFO_ARB_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end
      XFER: begin
        req_ready[grant_id] = !fifo_wfull;
        fifo_winc           = owner_valid & !fifo_wfull;
        if (fifo_winc) begin
          fifo_wdata = req_data[int'(grant_id)*WIDTH +: WIDTH];
          beat_d     = beat_cnt + 1'b1;
          // last beat and burst cap together still give a single release
          if (owner_last || beat_cnt == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
`ifdef FIFO_ARB_TIMEOUT_EN
        if (owner_valid) begin
          idle_d = '0;
        end else if (idle_cnt == IDLE_MAX) begin
          state_d     = IDLE;
          rr_ptr_d    = next_ptr;
          timeout_evt = 1'b1;
        end else begin
          idle_d = idle_cnt + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: handshake vector table, then scoreboarded burst
// scenarios (round-robin order, burst cap, full stall, reset mid-burst).
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_last = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_wfull = 1'b0;
  logic                     fifo_winc;
  logic [WIDTH-1:0]         fifo_wdata;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;
  arb_state_e               state_dbg;
`ifdef FIFO_ARB_TIMEOUT_EN
  logic                     timeout_evt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(16), .TIMEOUT(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wfull (fifo_wfull),
    .fifo_winc  (fifo_winc),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy),
`ifdef FIFO_ARB_TIMEOUT_EN
    .timeout_evt(timeout_evt),
`endif
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and producer model state
  logic [ID_W+WIDTH-1:0] exp_q[$];
  logic [8:0]            beats[NUM_REQ][32];
  int                    head[NUM_REQ];
  int                    tail[NUM_REQ];
  logic [NUM_REQ-1:0]    acc;
  logic                  auto_en, full_req;
  int                    n_vec, n_err, cyc, first_wr, last_wr;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic       busy;
    logic [1:0] grant;
    logic [3:0] ready;
    logic       winc;
    logic [7:0] wdata;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input int p, input logic [7:0] d, input logic l);
    beats[p][tail[p]] = {l, d};
    tail[p]++;
  endtask

  task automatic expect_wr(input int p, input logic [7:0] d);
    exp_q.push_back({2'(p), d});
  endtask

  task automatic drive();
    fifo_wfull = full_req;
    if (auto_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) head[i]++;
        if (head[i] < tail[i]) begin
          req_valid[i]                 = 1'b1;
          req_last[i]                  = beats[i][head[i]][8];
          req_data[i*WIDTH +: WIDTH]   = beats[i][head[i]][7:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  endtask

  task automatic monitor();
    logic [ID_W+WIDTH-1:0] e;
    acc = req_valid & req_ready;
    if (auto_en && fifo_winc) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got id %0d data %0h, expected no write", grant_id, fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_id_data", {22'd0, grant_id, fifo_wdata}, {22'd0, e});
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_drain(input int max, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max) begin
      cycle();
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d writes still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    auto_en   = 1'b0;
    full_req  = 1'b0;
    req_valid = '0;
    req_last  = '0;
    fifo_wfull = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    acc      = '0;
    first_wr = -1;
    last_wr  = -1;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    auto_en = 1'b1;
  endtask

  initial begin
    int k;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;

    // handshake vector table
    tbl[0] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
    tbl[1] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
    tbl[2] = '{4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 8'h00};
    tbl[3] = '{4'b0101, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h33};
    tbl[4] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 8'h00};
    tbl[5] = '{4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h33};
    tbl[6] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 8'h00};
    tbl[7] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h11};
    tbl[8] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};

    do_reset();
    auto_en  = 1'b0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int v = 0; v < 9; v++) begin
      @(posedge clk);
      #1;
      req_valid  = tbl[v].valid;
      req_last   = tbl[v].last;
      fifo_wfull = tbl[v].full;
      @(negedge clk);
      chk($sformatf("v%0d_busy", v),  {31'd0, busy},      {31'd0, tbl[v].busy});
      chk($sformatf("v%0d_grant", v), {30'd0, grant_id},  {30'd0, tbl[v].grant});
      chk($sformatf("v%0d_ready", v), {28'd0, req_ready}, {28'd0, tbl[v].ready});
      chk($sformatf("v%0d_winc", v),  {31'd0, fifo_winc}, {31'd0, tbl[v].winc});
      chk($sformatf("v%0d_wdata", v), {24'd0, fifo_wdata}, {24'd0, tbl[v].wdata});
    end

    // single producer, three beats, then rr_ptr should sit at 1
    do_reset();
    load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b0); load(0, 8'hA3, 1'b1);
    expect_wr(0, 8'hA1); expect_wr(0, 8'hA2); expect_wr(0, 8'hA3);
    wait_drain(20, "t1");
    chk("t1_three_beats_span", 32'(last_wr - first_wr), 32'd2);
    cycle();
    chk("t1_busy_after_last", {31'd0, busy}, 32'd0);
    load(0, 8'hB0, 1'b1); load(1, 8'hB1, 1'b1);
    expect_wr(1, 8'hB1); expect_wr(0, 8'hB0);
    wait_drain(20, "t1_rr");

    // all four producers, last every second beat
    do_reset();
    for (int b = 0; b < 4; b++)
      for (int p = 0; p < NUM_REQ; p++)
        load(p, 8'(8'h80 + p*16 + b), b[0]);
    for (int pr = 0; pr < 2; pr++)
      for (int p = 0; p < NUM_REQ; p++)
        for (int b = 2*pr; b < 2*pr + 2; b++)
          expect_wr(p, 8'(8'h80 + p*16 + b));
    wait_drain(60, "t2");
    chk("t2_bubble_span", 32'(last_wr - first_wr), 32'd22);

    // burst cap: producer 2 streams 20 beats, producer 3 waits with one beat
    do_reset();
    for (int b = 0; b < 20; b++) load(2, 8'(8'h20 + b), 1'b0);
    load(3, 8'hC3, 1'b1);
    for (int b = 0; b < 16; b++) expect_wr(2, 8'(8'h20 + b));
    expect_wr(3, 8'hC3);
    for (int b = 16; b < 20; b++) expect_wr(2, 8'(8'h20 + b));
    wait_drain(80, "t3");
    repeat (3) cycle();
    chk("t3_grant_held_busy", {31'd0, busy}, 32'd1);
    chk("t3_grant_held_id", {30'd0, grant_id}, 32'd2);

    // FIFO full for five cycles mid-burst
    do_reset();
    for (int b = 0; b < 6; b++) load(1, 8'(8'h50 + b), b == 5);
    for (int b = 0; b < 6; b++) expect_wr(1, 8'(8'h50 + b));
    k = 0;
    while (exp_q.size() != 4 && k < 20) begin
      cycle();
      k++;
    end
    chk("t4_reached_two_beats", exp_q.size(), 32'd4);
    full_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk($sformatf("t4_full%0d_ready", c), {28'd0, req_ready}, 32'd0);
      chk($sformatf("t4_full%0d_winc", c), {31'd0, fifo_winc}, 32'd0);
      chk($sformatf("t4_full%0d_busy", c), {31'd0, busy}, 32'd1);
    end
    full_req = 1'b0;
    wait_drain(20, "t4");

    // reset in the middle of a burst
    do_reset();
    load(0, 8'h60, 1'b1);
    for (int b = 0; b < 5; b++) load(1, 8'(8'h61 + b), b == 4);
    expect_wr(0, 8'h60);
    for (int b = 0; b < 5; b++) expect_wr(1, 8'(8'h61 + b));
    k = 0;
    while (exp_q.size() != 3 && k < 20) begin
      cycle();
      k++;
    end
    chk("t5_pre_grant", {30'd0, grant_id}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_winc", {31'd0, fifo_winc}, 32'd0);
    chk("t5_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("t5_rst_wdata", {24'd0, fifo_wdata}, 32'd0);
    chk("t5_rst_grant", {30'd0, grant_id}, 32'd0);
    do_reset();
    load(1, 8'h72, 1'b1); load(0, 8'h71, 1'b1);
    expect_wr(0, 8'h71); expect_wr(1, 8'h72);
    wait_drain(20, "t5");

`ifdef FIFO_ARB_TIMEOUT_EN
    // idle owner released by timeout
    begin
      int seen;
      do_reset();
      seen = 0;
      load(0, 8'h91, 1'b0); load(1, 8'h92, 1'b1);
      expect_wr(0, 8'h91); expect_wr(1, 8'h92);
      k = 0;
      while ((exp_q.size() != 0 || seen == 0) && k < 80) begin
        cycle();
        if (timeout_evt) seen++;
        k++;
      end
      chk("t6_timeout_pulses", seen, 32'd1);
      chk("t6_drain", exp_q.size(), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
